// File: rtl/dac_link_pkg.sv
// Shared types and constants for the DAC readback path.
// Defining READBACK_CHECKSUM_EN appends an XOR checksum byte to every readback.
package dac_link_pkg;

    localparam int DAC_FRAME_BITS = 24;
    localparam int UART_BYTE_BITS = 8;
`ifdef READBACK_CHECKSUM_EN
    localparam int READBACK_BYTES = 4;
`else
    localparam int READBACK_BYTES = 3;
`endif

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FRAME   = 3'd1,
        GAP     = 3'd2,
        SEND    = 3'd3,
        WAIT_HI = 3'd4,
        WAIT_LO = 3'd5
    } readback_state_t;

    typedef logic [DAC_FRAME_BITS-1:0] dac_word_t;

    // Byte idx of the host stream: MSB byte first, then the optional checksum.
    function automatic logic [UART_BYTE_BITS-1:0] readback_byte(input dac_word_t word,
                                                                input logic [1:0] idx);
        logic [UART_BYTE_BITS-1:0] b;
        case (idx)
            2'd0:    b = word[23:16];
            2'd1:    b = word[15:8];
            2'd2:    b = word[7:0];
`ifdef READBACK_CHECKSUM_EN
            default: b = word[23:16] ^ word[15:8] ^ word[7:0];
`else
            default: b = 8'h00;
`endif
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// One 24-bit SPI frame: SCLK divider, NOP word out on rising SCLK, DAC SDO
// sampled on falling SCLK. done_o marks the last frame cycle.
module spi_frame_shifter
    import dac_link_pkg::*;
#(
    parameter int        SCLK_DIV = 2,
    parameter dac_word_t NOP_WORD = 24'h000000
) (
    input  logic      clock,
    input  logic      reset_n,
    input  logic      start_i,
    input  logic      sdi_i,
    output logic      sclk_o,
    output logic      sync_n_o,
    output logic      sdo_o,
    output logic      done_o,
    output dac_word_t word_o
);

    localparam int               DIV_W     = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCLK_DIV - 1);
    localparam logic [5:0]       HALF_LAST = 6'(2 * DAC_FRAME_BITS - 1);

    logic             active_q, active_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [5:0]       half_q, half_d;
    logic             sclk_q, sclk_d;
    logic             sync_n_q, sync_n_d;
    logic             sdo_q, sdo_d;
    dac_word_t        nop_q, nop_d;
    dac_word_t        shift_q, shift_d;

    assign done_o   = active_q && (half_q == HALF_LAST) && (div_q == DIV_LAST);
    assign sclk_o   = sclk_q;
    assign sync_n_o = sync_n_q;
    assign sdo_o    = sdo_q;
    assign word_o   = shift_q;

    // Half-period sequencer: the 48th half-period end restores SCLK high and releases SYNC.
    always_comb begin
        active_d = active_q;
        div_d    = div_q;
        half_d   = half_q;
        sclk_d   = sclk_q;
        sync_n_d = sync_n_q;
        sdo_d    = sdo_q;
        nop_d    = nop_q;
        shift_d  = shift_q;
        if (start_i && !active_q) begin
            active_d = 1'b1;
            div_d    = '0;
            half_d   = 6'd0;
            sclk_d   = 1'b1;
            sync_n_d = 1'b0;
            sdo_d    = NOP_WORD[23];
            nop_d    = NOP_WORD << 1;
            shift_d  = '0;
        end else if (active_q) begin
            if (div_q == DIV_LAST) begin
                div_d  = '0;
                half_d = half_q + 6'd1;
                sclk_d = ~sclk_q;
                if (half_q == HALF_LAST) begin
                    active_d = 1'b0;
                    half_d   = 6'd0;
                    sclk_d   = 1'b1;
                    sync_n_d = 1'b1;
                    sdo_d    = 1'b0;
                end else if (sclk_q) begin
                    shift_d = {shift_q[22:0], sdi_i};
                end else begin
                    sdo_d = nop_q[23];
                    nop_d = nop_q << 1;
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end else begin
            sclk_d   = 1'b1;
            sync_n_d = 1'b1;
            sdo_d    = 1'b0;
        end
    end

    // Frame shifter state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            active_q <= 1'b0;
            div_q    <= '0;
            half_q   <= 6'd0;
            sclk_q   <= 1'b1;
            sync_n_q <= 1'b1;
            sdo_q    <= 1'b0;
            nop_q    <= '0;
            shift_q  <= '0;
        end else begin
            active_q <= active_d;
            div_q    <= div_d;
            half_q   <= half_d;
            sclk_q   <= sclk_d;
            sync_n_q <= sync_n_d;
            sdo_q    <= sdo_d;
            nop_q    <= nop_d;
            shift_q  <= shift_d;
        end
    end

endmodule

// File: rtl/dac_readback_receiver.sv
// Runs one DAC readback frame and streams the captured word to the UART.
// Build with READBACK_CHECKSUM_EN to append the XOR checksum byte.
module dac_readback_receiver
    import dac_link_pkg::*;
#(
    parameter int        SCLK_DIV = 2,
    parameter dac_word_t NOP_WORD = 24'h000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start_receive,
    output logic        rx_busy,
    output logic [23:0] readback_data,
    output logic        readback_valid,
    input  logic        dac_sdi,
    output logic        dac_sdo,
    output logic        dac_sclk,
    output logic        dac_sync_n,
    output logic [7:0]  uart_tx_data,
    output logic        uart_start_transmit,
    input  logic        uart_tx_busy
);

    localparam int               DIV_W     = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCLK_DIV - 1);
    localparam logic [1:0]       BYTE_LAST = 2'(READBACK_BYTES - 1);

    readback_state_t  state_q, state_d;
    logic [DIV_W-1:0] gap_q, gap_d;
    logic [1:0]       byte_q, byte_d;
    dac_word_t        word_q, word_d;
    logic             valid_q, valid_d;
    logic             rx_busy_q, rx_busy_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_start_q, tx_start_d;

    logic             start_accept_s;
    logic             frame_done_s;
    dac_word_t        frame_word_s;

    assign start_accept_s = (state_q == IDLE) && start_receive;

    spi_frame_shifter #(
        .SCLK_DIV (SCLK_DIV),
        .NOP_WORD (NOP_WORD)
    ) u_shifter (
        .clock    (clock),
        .reset_n  (reset_n),
        .start_i  (start_accept_s),
        .sdi_i    (dac_sdi),
        .sclk_o   (dac_sclk),
        .sync_n_o (dac_sync_n),
        .sdo_o    (dac_sdo),
        .done_o   (frame_done_s),
        .word_o   (frame_word_s)
    );

    // Readback sequencer; uart_start_transmit stays up until the UART acknowledges with busy.
    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        byte_d     = byte_q;
        word_d     = word_q;
        valid_d    = 1'b0;
        rx_busy_d  = rx_busy_q;
        tx_data_d  = tx_data_q;
        tx_start_d = tx_start_q;
        case (state_q)
            IDLE: begin
                if (start_receive) begin
                    state_d   = FRAME;
                    rx_busy_d = 1'b1;
                    byte_d    = 2'd0;
                end else begin
                    rx_busy_d = 1'b0;
                end
            end
            FRAME: begin
                if (frame_done_s) begin
                    state_d = GAP;
                    gap_d   = '0;
                    word_d  = frame_word_s;
                    valid_d = 1'b1;
                end else begin
                    state_d = FRAME;
                end
            end
            GAP: begin
                if (gap_q == DIV_LAST) begin
                    state_d = SEND;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + DIV_W'(1);
                end
            end
            SEND: begin
                if (!uart_tx_busy) begin
                    tx_data_d  = readback_byte(word_q, byte_q);
                    tx_start_d = 1'b1;
                    state_d    = WAIT_HI;
                end else begin
                    tx_start_d = 1'b0;
                end
            end
            WAIT_HI: begin
                if (uart_tx_busy) begin
                    tx_start_d = 1'b0;
                    state_d    = WAIT_LO;
                end else begin
                    tx_start_d = 1'b1;
                end
            end
            WAIT_LO: begin
                if (!uart_tx_busy) begin
                    if (byte_q == BYTE_LAST) begin
                        state_d   = IDLE;
                        rx_busy_d = 1'b0;
                        byte_d    = 2'd0;
                    end else begin
                        byte_d  = byte_q + 2'd1;
                        state_d = SEND;
                    end
                end else begin
                    state_d = WAIT_LO;
                end
            end
            default: begin
                state_d    = IDLE;
                rx_busy_d  = 1'b0;
                tx_start_d = 1'b0;
            end
        endcase
    end

    // Sequencer and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            gap_q      <= '0;
            byte_q     <= 2'd0;
            word_q     <= '0;
            valid_q    <= 1'b0;
            rx_busy_q  <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            byte_q     <= byte_d;
            word_q     <= word_d;
            valid_q    <= valid_d;
            rx_busy_q  <= rx_busy_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
        end
    end

    assign rx_busy             = rx_busy_q;
    assign readback_data       = word_q;
    assign readback_valid      = valid_q;
    assign uart_tx_data        = tx_data_q;
    assign uart_start_transmit = tx_start_q;

endmodule
